// File: rtl/bias_stream_pkg.sv
// Shared definitions for the bias/weight stream sink.
//   sink_state_e : load FSM state encoding
//   DEF_*        : default tensor geometry and precision
//   lane_lsb()   : lowest bit of lane j in a packed beat word
package bias_stream_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } sink_state_e;

  localparam int DEF_TENSOR_SIZE = 32;
  localparam int DEF_PARALLELISM = 4;
  localparam int DEF_PRECISION_0 = 16;
  localparam int DEF_PRECISION_1 = 3;

  function automatic int lane_lsb(input int j, input int p0);
    return j * p0;
  endfunction

endpackage

// File: rtl/bias_stream_sink_ram.sv
// DEPTH x WIDTH beat storage: one write port and a two-stage,
// ce0-gated read pipeline that matches the parameter ROM read timing.
//   clk, rst          : clock, synchronous active-high reset (pipeline only)
//   we, waddr, wdata  : write port
//   addr0, ce0        : read address / pipeline enable
//   q0                : read data, two enabled edges after addr0
module bias_stream_sink_ram #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  ce0,
  output logic [WIDTH-1:0]      q0
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] stage1_q, stage2_q;
  logic [WIDTH-1:0] rd_word;

  // Contents are not reset so a reload never needs a clearing pass.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_A)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Out-of-range addresses read as zero, like an unpopulated ROM word.
  always_comb begin
    rd_word = '0;
    if (addr0 < DEPTH_A) begin
      rd_word = mem[addr0[IDX_W-1:0]];
    end
  end

  // Sampled before the write lands, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else if (ce0) begin
      stage1_q <= rd_word;
      stage2_q <= stage1_q;
    end
  end

  assign q0 = stage2_q;

endmodule

// File: rtl/bias_stream_sink_buffer.sv
// Receiving end of the parameter stream. Captures DEPTH beats of
// PARALLELISM elements over valid/ready and serves them through a
// ROM-compatible two-cycle read port.
//   clk, rst                     : clock, synchronous active-high reset
//   data_in, data_in_valid/ready : incoming beat handshake
//   reload                       : pulse, restart loading from beat 0
//   loaded, fill_count           : load status (registered)
//   addr0, ce0, q0               : read port, lane j at q0[P0*j +: P0]
//
// state | meaning
// LOAD  | accepting beats into buffer[fill_count]
// FULL  | all DEPTH beats captured, input stalled
module bias_stream_sink_buffer
  import bias_stream_pkg::*;
#(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = DEF_TENSOR_SIZE,
  parameter int BIAS_PARALLELISM_DIM_0 = DEF_PARALLELISM,
  parameter int BIAS_PRECISION_0       = DEF_PRECISION_0,
  parameter int BIAS_PRECISION_1       = DEF_PRECISION_1,
  parameter int DEPTH                  = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
  parameter int ADDR_WIDTH             = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        reload,
  output logic                        loaded,
  output logic [ADDR_WIDTH-1:0]       fill_count,
  input  logic [ADDR_WIDTH-1:0]       addr0,
  input  logic                        ce0,
  output logic [BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0-1:0] q0
);

  localparam int WIDTH = BIAS_PRECISION_0 * BIAS_PARALLELISM_DIM_0;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);

  sink_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic                  loaded_q, loaded_d;
  logic                  accept;
  logic [WIDTH-1:0]      wdata;

  always_comb begin
    wdata = '0;
    for (int j = 0; j < BIAS_PARALLELISM_DIM_0; j++) begin
      wdata[lane_lsb(j, BIAS_PRECISION_0) +: BIAS_PRECISION_0] = data_in[j];
    end
  end

  // Ready depends on state only, so there is no valid-to-ready path.
  assign data_in_ready = (state_q == LOAD);
  assign accept        = data_in_valid & data_in_ready;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    loaded_d = loaded_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == LAST_A) begin
            state_d  = FULL;
            loaded_d = 1'b1;
          end
        end
      end
      FULL: begin
        loaded_d = 1'b1;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    // A beat accepted alongside reload is still written; only the count restarts.
    if (reload) begin
      state_d  = LOAD;
      fill_d   = '0;
      loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      fill_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      loaded_q <= loaded_d;
    end
  end

  assign loaded     = loaded_q;
  assign fill_count = fill_q;

  bias_stream_sink_ram #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (fill_q),
    .wdata (wdata),
    .addr0 (addr0),
    .ce0   (ce0),
    .q0    (q0)
  );

endmodule

// File: doc/bias_stream_sink_buffer.md
Name: bias_stream_sink_buffer

Overview:
- Receiving end of the parameter streaming interface.
- Accepts a bias/weight tensor streamed beat-by-beat over a valid/ready handshake (PARALLELISM elements per beat) and stores it in a local buffer.
- Exposes the stored tensor through an addressed read port with the same 2-cycle, ce0-gated latency as the parameter ROMs, so downstream logic can switch between a preloaded ROM and a runtime-loaded buffer without changes.
- Sits between a parameter source (DMA or streaming ROM) and the linear/bias-add datapath.

Parameters:
- BIAS_TENSOR_SIZE_DIM_0, 32, elements per tensor row.
- BIAS_PARALLELISM_DIM_0, 4, elements per beat; must divide BIAS_TENSOR_SIZE_DIM_0.
- BIAS_PRECISION_0, 16, element total width (bits).
- BIAS_PRECISION_1, 3, fractional bits; carried for metadata only, no arithmetic.
- DEPTH, BIAS_TENSOR_SIZE_DIM_0/BIAS_PARALLELISM_DIM_0, beats per tensor (default 8).
- ADDR_WIDTH, $clog2(DEPTH)+1, read-address and fill-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  BIAS_PRECISION_0 x BIAS_PARALLELISM_DIM_0 (unpacked array)  beat elements; element j occupies lane j.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  buffer accepts a beat.
- reload  in  1  single-cycle pulse; discard contents and restart loading.
- loaded  out  1  all DEPTH beats captured.
- fill_count  out  ADDR_WIDTH  beats captured since last reset/reload.
- addr0  in  ADDR_WIDTH  read beat address.
- ce0  in  1  read pipeline enable.
- q0  out  BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0  read data; lane j at bits [P0*j+P0-1 : P0*j].

Behaviour:
- States: LOAD, FULL. Reset enters LOAD.
- Reset values: fill_count=0, loaded=0, data_in_ready=1 (LOAD), q0 pipeline registers=0. Buffer contents are not cleared.
- LOAD state:
  - data_in_ready=1.
  - Handshake fires when data_in_valid & data_in_ready; the beat is written to buffer[fill_count] in that cycle, and fill_count increments.
  - When the accepted beat has fill_count==DEPTH-1: next state FULL, fill_count=DEPTH, loaded=1 from the next cycle.
- FULL state:
  - data_in_ready=0 and loaded=1.
  - data_in_valid is ignored; no writes, no overflow possible.
- reload:
  - From any state, next cycle is LOAD with fill_count=0 and loaded=0.
  - If reload coincides with an accepted beat, the beat is still written, then the count restarts at 0. reload has priority over the FULL transition.
- Read port:
  - When ce0=1, stage1 <= buffer[addr0] and stage2 <= stage1; q0=stage2. Latency is 2 cycles.
  - When ce0=0, both stages hold.
  - addr0 >= DEPTH reads 0.
  - Reads are allowed in any state. Reading a slot written in the same cycle returns the old contents (read-before-write).
- Registered outputs: loaded and fill_count change only on clock edges.
- Reset mid-load: all state is discarded and loading restarts from beat 0.
- Valid/ready discipline: the sink never depends on a valid→ready combinational path; data_in_ready is a function of state only.

Decomposition:
- Shared package (bias_stream_pkg):
  - State enum {LOAD, FULL}.
  - Lane-slice helper function (index j → bit range).
  - Default precision constants.
- One sub-module: bias_stream_sink_ram, the DEPTH x (P0*PAR) storage with one write port and the 2-stage ce0 read pipeline. It mirrors the ROM read timing.
- The top holds the FSM, counter and handshake.

Test Plan:
- Reset, then 8 back-to-back beats with beat k lanes = {4k+3, 4k+2, 4k+1, 4k}:
  - data_in_ready stays high for 8 cycles, then drops.
  - loaded=1 and fill_count=8 one cycle after the 8th handshake.
  - Reading addr0=5 with ce0=1 gives q0 lanes {23,22,21,20} two cycles later.
- Valid toggling 1,0,1,0 with random gaps: only valid cycles count. After 8 valid beats loaded=1; a 9th valid beat presented in FULL is not accepted and the buffer is unchanged.
- ce0 held low for 3 cycles mid-read: q0 is frozen. When ce0 returns high, the next address's data appears after 2 enabled edges. addr0=9 reads 0.
- reload asserted together with the 8th beat: beat 7 is written, fill_count=0, loaded stays 0, ready stays 1. A new 8-beat stream then overwrites and loaded rises.
- rst asserted after 3 beats: fill_count=0 and loaded=0. A following full stream loads correctly from beat 0.
- Read of addr 2 in the same cycle it is written: returns the old value. A read the next cycle returns the new value.
